alloc_cmdq: RTL and testbench
=============================

ALLOC_CMDQ -- requirements
Module: alloc_cmdq

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2, command FIFO depth = 2**DEPTH_LOG2 entries.
REQ-002 SHALL have parameter RD_LAT, default 1, cycles from allocator strobe to valid i_alloc_addr/i_rdata/i_err (range 1..7).
REQ-003 SHALL have ports:
 i_clk  in  1  system clock, all logic on rising edge
 i_rst_n  in  1  asynchronous active-low reset
 i_cmd_valid  in  1  upstream command valid
 o_cmd_ready  out  1  command accepted when valid&ready
 i_cmd_op  in  2  00 alloc, 01 free, 10 read, 11 write
 i_cmd_addr  in  16  free/read/write address
 i_cmd_data  in  16  alloc init data / write data
 o_alloc  out  1  allocator alloc strobe
 o_data  out  16  alloc init data
 i_alloc_addr  in  16  allocated address from allocator
 o_free  out  1  allocator free strobe
 o_addr  out  16  free address
 o_rd  out  1  RAM read strobe
 o_raddr  out  8  read address = cmd_addr[7:0]
 i_rdata  in  16  RAM read data
 o_wr  out  1  RAM write strobe
 o_waddr  out  8  write address = cmd_addr[7:0]
 o_wdata  out  16  write data
 i_err  in  1  allocator error
 o_rsp_valid  out  1  response valid
 i_rsp_ready  in  1  response consumed when valid&ready
 o_rsp_data  out  16  alloc: i_alloc_addr; read: i_rdata; free/write: 16'h0000
 o_rsp_err  out  1  i_err sampled with result

Function
REQ-004 SHALL buffer commands in a FIFO of 2**DEPTH_LOG2 entries {op, addr, data}; o_cmd_ready = FIFO not full.
REQ-005 SHALL accept push and pop in the same cycle when not full; when full, o_cmd_ready=0 and no push occurs.
REQ-006 SHALL run FSM states IDLE, ISSUE, WAIT, RESP; exactly one command in flight.
REQ-007 IDLE: if FIFO non-empty at a clock edge, SHALL pop head into command register and enter ISSUE; else remain IDLE.
REQ-008 ISSUE: SHALL assert exactly one strobe (o_alloc/o_free/o_rd/o_wr per op) for exactly one cycle, strobes decoded from registered state only; then enter WAIT.
REQ-009 WAIT: SHALL count RD_LAT cycles after the ISSUE cycle, then capture o_rsp_data and o_rsp_err from i_alloc_addr/i_rdata/i_err and enter RESP (or IDLE per REQ-016).
REQ-010 RESP: SHALL hold o_rsp_valid=1 and o_rsp_data/o_rsp_err stable until i_rsp_ready=1, then enter IDLE.
REQ-011 Minimum command-to-response latency (empty FIFO, IDLE): push at edge k, ISSUE cycle after edge k+1, o_rsp_valid high after edge k+2+RD_LAT.
REQ-012 o_data/o_addr/o_raddr/o_waddr/o_wdata SHALL be driven from the command register and stable throughout ISSUE and WAIT.
REQ-013 Strobes SHALL be 0 in IDLE, WAIT, RESP; never two strobes in one cycle.
REQ-014 Backpressure on i_rsp_ready SHALL stall issue; FIFO continues accepting until full.

Reset
REQ-015 On i_rst_n=0 (asynchronous, any state): FSM=IDLE, FIFO empty, all strobes 0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_cmd_ready=1 after release; in-flight command and response discarded.

Configuration
REQ-016 Macro ALLOC_CMDQ_WR_ACK_EN: defined -> free/write produce a response (data 16'h0000, err sampled); undefined -> free/write go WAIT->IDLE without response, o_rsp_valid never asserted for them.

Verification
REQ-017 Reset then alloc (data 16'h1234), RD_LAT=1, i_alloc_addr=16'h5003 -> o_alloc one cycle with o_data=16'h1234; o_rsp_valid 3 cycles after push, o_rsp_data=16'h5003.
REQ-018 Write addr 16'h0007 data 16'h0005 then read addr 16'h0007, model returns 16'h0005 -> o_wr with o_waddr=8'h07, then o_rd with o_raddr=8'h07, read o_rsp_data=16'h0005; write response present only with ALLOC_CMDQ_WR_ACK_EN.
REQ-019 i_rsp_ready=0, push 5 commands (DEPTH_LOG2=2) -> 1 in flight, 4 buffered, o_cmd_ready=0; 5th-plus push blocked; release ready -> responses in push order.
REQ-020 Free with i_err=1 at capture -> o_rsp_err=1 (macro defined); no response (macro undefined); next command unaffected.
REQ-021 Assert i_rst_n=0 during WAIT with 2 commands queued -> strobes and o_rsp_valid 0 immediately; after release no strobe occurs until a new command is pushed.

Source files
------------

// File: rtl/alloc_cmdq.sv
// Command queue front-end for a memory allocator and RAM: buffers commands, issues one at a time, returns responses.
// Optional macro ALLOC_CMDQ_WR_ACK_EN: when defined, free/write commands also return a (zero-data) response.
module alloc_cmdq #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [15:0] i_cmd_addr,
  input  logic [15:0] i_cmd_data,
  output logic        o_alloc,
  output logic [15:0] o_data,
  input  logic [15:0] i_alloc_addr,
  output logic        o_free,
  output logic [15:0] o_addr,
  output logic        o_rd,
  output logic [7:0]  o_raddr,
  input  logic [15:0] i_rdata,
  output logic        o_wr,
  output logic [7:0]  o_waddr,
  output logic [15:0] o_wdata,
  input  logic        i_err,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_data,
  output logic        o_rsp_err
);

  localparam int unsigned            DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]    FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [2:0]             LAT_INIT = 3'(RD_LAT - 1);
`ifdef ALLOC_CMDQ_WR_ACK_EN
  localparam logic                   WR_ACK   = 1'b1;
`else
  localparam logic                   WR_ACK   = 1'b0;
`endif

  typedef enum logic [1:0] {
    OP_ALLOC = 2'b00,
    OP_FREE  = 2'b01,
    OP_READ  = 2'b10,
    OP_WRITE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  logic [33:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   cnt_q;
  logic                  full, empty, push, pop;
  logic [33:0]           head;

  state_t                state_q;
  op_t                   op_q;
  logic [15:0]           addr_q, data_q;
  logic [2:0]            lat_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [15:0]           rsp_data_q;

  assign full        = (cnt_q == FULL_CNT);
  assign empty       = (cnt_q == '0);
  assign o_cmd_ready = ~full;
  assign push        = i_cmd_valid & ~full;
  assign pop         = (state_q == ST_IDLE) & ~empty;
  assign head        = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_cmd_op, i_cmd_addr, i_cmd_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Responses are captured on the last WAIT edge, RD_LAT cycles after the strobe cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ALLOC;
      addr_q      <= '0;
      data_q      <= '0;
      lat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            op_q    <= op_t'(head[33:32]);
            addr_q  <= head[31:16];
            data_q  <= head[15:0];
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          lat_q   <= LAT_INIT;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_q != '0) begin
            lat_q <= lat_q - 1'b1;
          end else if ((op_q == OP_ALLOC) || (op_q == OP_READ) || WR_ACK) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= i_err;
            unique case (op_q)
              OP_ALLOC: rsp_data_q <= i_alloc_addr;
              OP_READ:  rsp_data_q <= i_rdata;
              default:  rsp_data_q <= '0;
            endcase
            state_q <= ST_RESP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_alloc     = (state_q == ST_ISSUE) && (op_q == OP_ALLOC);
  assign o_free      = (state_q == ST_ISSUE) && (op_q == OP_FREE);
  assign o_rd        = (state_q == ST_ISSUE) && (op_q == OP_READ);
  assign o_wr        = (state_q == ST_ISSUE) && (op_q == OP_WRITE);
  assign o_data      = data_q;
  assign o_addr      = addr_q;
  assign o_raddr     = addr_q[7:0];
  assign o_waddr     = addr_q[7:0];
  assign o_wdata     = data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alloc_cmdq.sv
// Directed bench for alloc_cmdq with a small RAM model; expectations follow ALLOC_CMDQ_WR_ACK_EN if defined.
module tb_alloc_cmdq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_op = 2'b00;
  logic [15:0] i_cmd_addr = '0;
  logic [15:0] i_cmd_data = '0;
  logic        o_alloc;
  logic [15:0] o_data;
  logic [15:0] i_alloc_addr = '0;
  logic        o_free;
  logic [15:0] o_addr;
  logic        o_rd;
  logic [7:0]  o_raddr;
  logic [15:0] i_rdata;
  logic        o_wr;
  logic [7:0]  o_waddr;
  logic [15:0] o_wdata;
  logic        i_err = 1'b0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [15:0] o_rsp_data;
  logic        o_rsp_err;

`ifdef ALLOC_CMDQ_WR_ACK_EN
  localparam int unsigned WR_RSP = 1;
`else
  localparam int unsigned WR_RSP = 0;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 i_clk = ~i_clk;

  alloc_cmdq #(.DEPTH_LOG2(2), .RD_LAT(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_alloc(o_alloc), .o_data(o_data), .i_alloc_addr(i_alloc_addr),
    .o_free(o_free), .o_addr(o_addr),
    .o_rd(o_rd), .o_raddr(o_raddr), .i_rdata(i_rdata),
    .o_wr(o_wr), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .i_err(i_err),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err)
  );

  // RAM with one cycle of read latency; unwritten words read back as {8'hA0, addr}.
  logic [15:0]  ram [256];
  logic [255:0] ram_vld = '0;
  always @(posedge i_clk) begin
    if (o_wr) begin
      ram[o_waddr]     <= o_wdata;
      ram_vld[o_waddr] <= 1'b1;
    end
    if (o_rd) i_rdata <= ram_vld[o_raddr] ? ram[o_raddr] : {8'hA0, o_raddr};
  end

  int unsigned cyc = 0, n_alloc = 0, n_free = 0, n_rd = 0, n_wr = 0, n_multi = 0, rsp_n = 0;
  int unsigned wr_cyc = 0, rd_cyc = 0;
  logic [7:0]  last_waddr = '0, last_raddr = '0;
  logic [15:0] last_wdata = '0, last_faddr = '0;
  logic [15:0] rsp_data_log [64];
  logic        rsp_err_log [64];

  always @(negedge i_clk) begin
    cyc <= cyc + 1;
    if (o_alloc) n_alloc <= n_alloc + 1;
    if (o_free) begin n_free <= n_free + 1; last_faddr <= o_addr; end
    if (o_rd) begin n_rd <= n_rd + 1; last_raddr <= o_raddr; rd_cyc <= cyc; end
    if (o_wr) begin n_wr <= n_wr + 1; last_waddr <= o_waddr; last_wdata <= o_wdata; wr_cyc <= cyc; end
    if ($countones({o_alloc, o_free, o_rd, o_wr}) > 1) n_multi <= n_multi + 1;
    if (o_rsp_valid && i_rsp_ready && rsp_n < 64) begin
      rsp_data_log[rsp_n] <= o_rsp_data;
      rsp_err_log[rsp_n]  <= o_rsp_err;
      rsp_n <= rsp_n + 1;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
    logic acc = 1'b0;
    int   n   = 0;
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_addr  = addr;
    i_cmd_data  = data;
    while (!acc && n < 50) begin
      @(negedge i_clk);
      acc = o_cmd_ready;
      @(posedge i_clk);
      #1;
      n++;
    end
    i_cmd_valid = 1'b0;
    checks++;
    if (acc !== 1'b1) begin failures++; $display("FAIL push_accept got=%0b want=1 op=%0d", acc, op); end
  endtask

  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    tick();
    checks++;
    if ({o_alloc, o_free, o_rd, o_wr} !== 4'b0000) begin failures++; $display("FAIL reset_strobes got=%b want=0000", {o_alloc, o_free, o_rd, o_wr}); end
    checks++;
    if ({o_rsp_valid, o_rsp_err, o_rsp_data} !== 18'h0) begin failures++; $display("FAIL reset_rsp got=%0b/%0b/%h want=0/0/0000", o_rsp_valid, o_rsp_err, o_rsp_data); end
    tick();
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (o_cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b want=1", o_cmd_ready); end
  endtask

  task automatic test_alloc();
    int unsigned r0 = rsp_n;
    i_rsp_ready  = 1'b0;
    i_alloc_addr = 16'h5003;
    push(2'b00, 16'h0000, 16'h1234);
    checks++;
    if (o_alloc !== 1'b0) begin failures++; $display("FAIL alloc_early got=%0b want=0", o_alloc); end
    tick();
    checks++;
    if (o_alloc !== 1'b1 || o_data !== 16'h1234) begin failures++; $display("FAIL alloc_issue got=%0b/%h want=1/1234", o_alloc, o_data); end
    checks++;
    if ({o_free, o_rd, o_wr} !== 3'b000) begin failures++; $display("FAIL alloc_other_strobes got=%b want=000", {o_free, o_rd, o_wr}); end
    tick();
    checks++;
    if (o_alloc !== 1'b0 || o_rsp_valid !== 1'b0 || o_data !== 16'h1234) begin failures++; $display("FAIL alloc_wait got=%0b/%0b/%h want=0/0/1234", o_alloc, o_rsp_valid, o_data); end
    tick();
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'h5003 || o_rsp_err !== 1'b0) begin failures++; $display("FAIL alloc_rsp got=%0b/%h/%0b want=1/5003/0", o_rsp_valid, o_rsp_data, o_rsp_err); end
    i_alloc_addr = 16'hFFFF;
    i_err = 1'b1;
    tick();
    tick();
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'h5003 || o_rsp_err !== 1'b0) begin failures++; $display("FAIL alloc_rsp_hold got=%0b/%h/%0b want=1/5003/0", o_rsp_valid, o_rsp_data, o_rsp_err); end
    i_err = 1'b0;
    i_rsp_ready = 1'b1;
    tick();
    checks++;
    if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL alloc_rsp_drop got=%0b want=0", o_rsp_valid); end
    checks++;
    if (rsp_n - r0 != 1 || n_alloc != 1) begin failures++; $display("FAIL alloc_counts got=%0d/%0d want=1/1", rsp_n - r0, n_alloc); end
  endtask

  task automatic test_write_read();
    int unsigned r0 = rsp_n, w0 = n_wr, d0 = n_rd;
    i_rsp_ready = 1'b1;
    push(2'b11, 16'h0007, 16'h0005);
    push(2'b10, 16'h0007, 16'h0000);
    repeat (12) tick();
    checks++;
    if (n_wr - w0 != 1 || last_waddr !== 8'h07 || last_wdata !== 16'h0005) begin failures++; $display("FAIL wr_strobe got=%0d/%h/%h want=1/07/0005", n_wr - w0, last_waddr, last_wdata); end
    checks++;
    if (n_rd - d0 != 1 || last_raddr !== 8'h07) begin failures++; $display("FAIL rd_strobe got=%0d/%h want=1/07", n_rd - d0, last_raddr); end
    checks++;
    if (!(wr_cyc < rd_cyc)) begin failures++; $display("FAIL wr_before_rd got=wr%0d/rd%0d want=wr<rd", wr_cyc, rd_cyc); end
    checks++;
    if (rsp_n - r0 != 1 + WR_RSP) begin failures++; $display("FAIL wr_rd_rsp_count got=%0d want=%0d", rsp_n - r0, 1 + WR_RSP); end
`ifdef ALLOC_CMDQ_WR_ACK_EN
    checks++;
    if (rsp_data_log[r0] !== 16'h0000) begin failures++; $display("FAIL wr_ack_data got=%h want=0000", rsp_data_log[r0]); end
`endif
    checks++;
    if (rsp_data_log[r0 + WR_RSP] !== 16'h0005) begin failures++; $display("FAIL rd_data got=%h want=0005", rsp_data_log[r0 + WR_RSP]); end
  endtask

  task automatic test_backpressure();
    int unsigned r0 = rsp_n, d0 = n_rd;
    logic [15:0] exp;
    i_rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(2'b10, 16'h0010 + 16'(i), 16'h0000);
    checks++;
    if (o_cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%0b want=0", o_cmd_ready); end
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'hA010) begin failures++; $display("FAIL bp_head_rsp got=%0b/%h want=1/a010", o_rsp_valid, o_rsp_data); end
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'b10;
    i_cmd_addr  = 16'h0015;
    repeat (3) tick();
    checks++;
    if (o_cmd_ready !== 1'b0 || n_rd - d0 != 1) begin failures++; $display("FAIL bp_blocked got=%0b/%0d want=0/1", o_cmd_ready, n_rd - d0); end
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b1;
    repeat (30) tick();
    checks++;
    if (rsp_n - r0 != 5 || n_rd - d0 != 5) begin failures++; $display("FAIL bp_drain got=%0d/%0d want=5/5", rsp_n - r0, n_rd - d0); end
    for (int i = 0; i < 5; i++) begin
      exp = 16'hA010 + 16'(i);
      checks++;
      if (rsp_data_log[r0 + i] !== exp) begin failures++; $display("FAIL bp_order[%0d] got=%h want=%h", i, rsp_data_log[r0 + i], exp); end
    end
  endtask

  task automatic test_free_err();
    int unsigned r0 = rsp_n, f0 = n_free;
    i_rsp_ready  = 1'b1;
    i_alloc_addr = 16'h6000;
    i_err = 1'b1;
    push(2'b01, 16'h0042, 16'h0000);
    push(2'b00, 16'h0000, 16'h1111);
    tick();
    tick();
    i_err = 1'b0;
    repeat (10) tick();
    checks++;
    if (n_free - f0 != 1 || last_faddr !== 16'h0042) begin failures++; $display("FAIL free_strobe got=%0d/%h want=1/0042", n_free - f0, last_faddr); end
    checks++;
    if (rsp_n - r0 != 1 + WR_RSP) begin failures++; $display("FAIL free_rsp_count got=%0d want=%0d", rsp_n - r0, 1 + WR_RSP); end
`ifdef ALLOC_CMDQ_WR_ACK_EN
    checks++;
    if (rsp_data_log[r0] !== 16'h0000 || rsp_err_log[r0] !== 1'b1) begin failures++; $display("FAIL free_rsp got=%h/%0b want=0000/1", rsp_data_log[r0], rsp_err_log[r0]); end
`endif
    checks++;
    if (rsp_data_log[r0 + WR_RSP] !== 16'h6000 || rsp_err_log[r0 + WR_RSP] !== 1'b0) begin failures++; $display("FAIL after_free_alloc got=%h/%0b want=6000/0", rsp_data_log[r0 + WR_RSP], rsp_err_log[r0 + WR_RSP]); end
  endtask

  task automatic test_reset_midflight();
    int unsigned r0, s0;
    i_rsp_ready = 1'b1;
    push(2'b10, 16'h0010, 16'h0000);
    push(2'b10, 16'h0011, 16'h0000);
    push(2'b10, 16'h0012, 16'h0000);
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_alloc, o_free, o_rd, o_wr, o_rsp_valid} !== 5'b00000) begin failures++; $display("FAIL rst_mid_outputs got=%b want=00000", {o_alloc, o_free, o_rd, o_wr, o_rsp_valid}); end
    checks++;
    if (o_rsp_data !== 16'h0000 || o_rsp_err !== 1'b0 || o_cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_state got=%h/%0b/%0b want=0000/0/1", o_rsp_data, o_rsp_err, o_cmd_ready); end
    tick();
    tick();
    i_rst_n = 1'b1;
    r0 = rsp_n;
    s0 = n_alloc + n_free + n_rd + n_wr;
    repeat (8) tick();
    checks++;
    if (n_alloc + n_free + n_rd + n_wr != s0 || rsp_n != r0) begin failures++; $display("FAIL rst_mid_quiet got=%0d/%0d want=0/0", n_alloc + n_free + n_rd + n_wr - s0, rsp_n - r0); end
    i_alloc_addr = 16'h7777;
    push(2'b00, 16'h0000, 16'h2222);
    repeat (6) tick();
    checks++;
    if (rsp_n - r0 != 1 || rsp_data_log[r0] !== 16'h7777) begin failures++; $display("FAIL rst_mid_resume got=%0d/%h want=1/7777", rsp_n - r0, rsp_data_log[r0]); end
  endtask

  task automatic test_strobe_exclusive();
    checks++;
    if (n_multi != 0) begin failures++; $display("FAIL strobe_exclusive got=%0d want=0", n_multi); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_write_read();
    test_backpressure();
    test_free_err();
    test_reset_midflight();
    test_strobe_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
